// File: rtl/ddr_clock_divider.sv
// Programmable half-cycle-resolution clock divider producing DDR phase bits (q0 first half, q1 second half).
// Latency: outputs registered, one cycle after the half-cycle position they describe.
// Backpressure: cfg_ready low while a config is pending; it is applied at a period wrap, on sync, or at once while disabled.
//
// Ports:
//   clk, rst_n          divider clock, asynchronous active-low reset
//   enable              run divider; low forces outputs low and parks the position
//   sync                restarts the period at the load position on the next cycle
//   cfg_period/high     new period and high time in half-cycles (cfg_valid/cfg_ready handshake)
//   cfg_offset          start position for loads, only with DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN defined
//   q0, q1              DDR half-cycle levels
//   period_start(_odd)  a period begins in this output cycle (in its second half)
module ddr_clock_divider #(
   parameter int WIDTH          = 16,
   parameter int DEFAULT_PERIOD = 50,
   parameter int DEFAULT_HIGH   = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sync,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_high,
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
   input  logic [WIDTH-1:0] cfg_offset,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             q0,
   output logic             q1,
   output logic             period_start,
   output logic             period_start_odd
);

   localparam int W1 = WIDTH + 1;

   // Active and shadow configuration, half-cycle position
   logic [WIDTH-1:0] h_q, h_d;
   logic [WIDTH-1:0] per_q, per_d, high_q, high_d;
   logic [WIDTH-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
   logic             pend_q, pend_d;
   logic             q0_d, q1_d, ps_d, pso_d;

   logic [WIDTH-1:0] off_cur, off_new;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
   logic [WIDTH-1:0] off_q, off_d, sh_off_q, sh_off_d;
   assign off_cur = off_q;
   assign off_new = sh_off_q;
`else
   assign off_cur = '0;
   assign off_new = '0;
`endif

   // Derived per-cycle quantities
   logic [WIDTH-1:0] pe_cur, pe_new;
   logic [W1-1:0]    h1p, h2p;
   logic             wrap, last_half;
   logic [WIDTH-1:0] h1, h_inc, h_rem, h_rem_clamp;
   logic [WIDTH-1:0] load_cur, load_new;
   logic             accept;

   // Periods below 2 half-cycles cannot produce a full output cycle, so run them as 2.
   assign pe_cur = (per_q    < WIDTH'(2)) ? WIDTH'(2) : per_q;
   assign pe_new = (sh_per_q < WIDTH'(2)) ? WIDTH'(2) : sh_per_q;

   // Comparisons are done one bit wider so h+2 never overflows near the top of the range.
   assign h1p       = {1'b0, h_q} + W1'(1);
   assign h2p       = {1'b0, h_q} + W1'(2);
   assign wrap      = (h2p >= {1'b0, pe_cur});
   assign last_half = (h1p == {1'b0, pe_cur});

   // The narrow sums are exact whenever they are selected: the true result is below Pe.
   assign h1          = last_half ? '0 : (h_q + WIDTH'(1));
   assign h_inc       = h_q + WIDTH'(2);
   assign h_rem       = h_q + WIDTH'(2) - pe_cur;
   assign h_rem_clamp = (h_rem >= pe_new) ? '0 : h_rem;

   // An offset outside the period would never be reached, so it starts at 0 instead.
   assign load_cur = (off_cur >= pe_cur) ? '0 : off_cur;
   assign load_new = (off_new >= pe_new) ? '0 : off_new;

   assign cfg_ready = ~pend_q;
   assign accept    = cfg_valid & ~pend_q;

   always_comb begin
      h_d       = h_q;
      per_d     = per_q;
      high_d    = high_q;
      sh_per_d  = sh_per_q;
      sh_high_d = sh_high_q;
      pend_d    = pend_q;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
      off_d     = off_q;
      sh_off_d  = sh_off_q;
`endif
      q0_d      = 1'b0;
      q1_d      = 1'b0;
      ps_d      = 1'b0;
      pso_d     = 1'b0;

      // Capture and apply are mutually exclusive: capture needs no pending config, apply needs one.
      if (accept) begin
         sh_per_d  = cfg_period;
         sh_high_d = cfg_high;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
         sh_off_d  = cfg_offset;
`endif
         pend_d    = 1'b1;
      end

      if (!enable) begin
         // Parked at the load position so the first enabled cycle starts a period.
         if (pend_q) begin
            per_d  = sh_per_q;
            high_d = sh_high_q;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
            off_d  = sh_off_q;
`endif
            pend_d = 1'b0;
            h_d    = load_new;
         end else begin
            h_d = load_cur;
         end
      end else begin
         q0_d  = (h_q < high_q);
         q1_d  = (h1 < high_q);
         ps_d  = (h_q == '0) | last_half;
         pso_d = last_half;

         if (sync) begin
            if (pend_q) begin
               per_d  = sh_per_q;
               high_d = sh_high_q;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
               off_d  = sh_off_q;
`endif
               pend_d = 1'b0;
               h_d    = load_new;
            end else begin
               h_d = load_cur;
            end
         end else if (wrap) begin
            // New config takes effect only at a period boundary, continuing from the wrap remainder.
            if (pend_q) begin
               per_d  = sh_per_q;
               high_d = sh_high_q;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
               off_d  = sh_off_q;
`endif
               pend_d = 1'b0;
               h_d    = h_rem_clamp;
            end else begin
               h_d = h_rem;
            end
         end else begin
            h_d = h_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q              <= '0;
         per_q            <= WIDTH'(DEFAULT_PERIOD);
         high_q           <= WIDTH'(DEFAULT_HIGH);
         sh_per_q         <= WIDTH'(DEFAULT_PERIOD);
         sh_high_q        <= WIDTH'(DEFAULT_HIGH);
         pend_q           <= 1'b0;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
         off_q            <= '0;
         sh_off_q         <= '0;
`endif
         q0               <= 1'b0;
         q1               <= 1'b0;
         period_start     <= 1'b0;
         period_start_odd <= 1'b0;
      end else begin
         h_q              <= h_d;
         per_q            <= per_d;
         high_q           <= high_d;
         sh_per_q         <= sh_per_d;
         sh_high_q        <= sh_high_d;
         pend_q           <= pend_d;
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
         off_q            <= off_d;
         sh_off_q         <= sh_off_d;
`endif
         q0               <= q0_d;
         q1               <= q1_d;
         period_start     <= ps_d;
         period_start_odd <= pso_d;
      end
   end

endmodule

// File: tb/tb_ddr_clock_divider.sv
// Directed bench for ddr_clock_divider with hand-computed output vectors.
// Vectors are {q0, q1, period_start, period_start_odd}, sampled 1 time unit after each rising edge.
// Inputs change at the same sample point, taking effect on the following edge.
module tb_ddr_clock_divider;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic             sync;
   logic [WIDTH-1:0] cfg_period;
   logic [WIDTH-1:0] cfg_high;
   logic [WIDTH-1:0] cfg_offset;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             q0, q1, period_start, period_start_odd;

   int checks = 0;
   int errors = 0;

   logic [3:0] p5 [0:4];

   ddr_clock_divider #(
      .WIDTH         (WIDTH),
      .DEFAULT_PERIOD(50),
      .DEFAULT_HIGH  (25)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .sync            (sync),
      .cfg_period      (cfg_period),
      .cfg_high        (cfg_high),
`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
      .cfg_offset      (cfg_offset),
`endif
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .q0              (q0),
      .q1              (q1),
      .period_start    (period_start),
      .period_start_odd(period_start_odd)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   function automatic logic [3:0] outv();
      return {q0, q1, period_start, period_start_odd};
   endfunction

   // P=50/H=25 output cycle m of a 25-cycle period: 12x 11, one 10, 12x 00.
   function automatic logic [3:0] dflt(input int m);
      logic [1:0] q;
      q = (m < 12) ? 2'b11 : ((m == 12) ? 2'b10 : 2'b00);
      return {q, (m == 0), 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Load a config while disabled (applied one cycle after capture), then re-enable.
   task automatic cfg_disabled(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] h);
      enable     = 1'b0;
      cfg_valid  = 1'b1;
      cfg_period = p;
      cfg_high   = h;
      tick();
      cfg_valid  = 1'b0;
      tick();
      enable     = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      sync       = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_high   = '0;
      cfg_offset = '0;
      p5[0] = 4'b1110;   // h=0
      p5[1] = 4'b0000;   // h=2
      p5[2] = 4'b0111;   // h=4, next period starts in second half
      p5[3] = 4'b1000;   // h=1
      p5[4] = 4'b0000;   // h=3

      // Reset state
      repeat (3) tick();
      chk("reset_out", outv(), 4'b0000);
      chk("reset_rdy", {3'b0, cfg_ready}, 4'b0001);
      rst_n = 1'b1;
      tick();
      chk("disabled_out", outv(), 4'b0000);

      // Defaults, two full periods, period_start on first output cycle
      enable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("default", outv(), dflt(k % 25));
      end

      // Reconfigure mid-period to P=20, H=10: old period completes intact
      for (int m = 0; m < 5; m++) begin
         tick();
         chk("pre_reconf", outv(), dflt(m));
      end
      cfg_valid  = 1'b1;
      cfg_period = 20;
      cfg_high   = 10;
      tick();
      cfg_valid  = 1'b0;
      chk("reconf_accept_out", outv(), dflt(5));
      chk("reconf_accept_rdy", {3'b0, cfg_ready}, 4'b0000);
      for (int m = 6; m < 25; m++) begin
         tick();
         chk("reconf_old", outv(), dflt(m));
         chk("reconf_rdy", {3'b0, cfg_ready}, {3'b0, (m == 24)});
      end
      for (int j = 0; j < 20; j++) begin
         tick();
         chk("p20", outv(), {((j % 10) < 5) ? 2'b11 : 2'b00, ((j % 10) == 0), 1'b0});
      end

      // P=5, H=2 loaded while disabled
      enable = 1'b0;
      tick();
      chk("disable_out", outv(), 4'b0000);
      cfg_valid  = 1'b1;
      cfg_period = 5;
      cfg_high   = 2;
      tick();
      cfg_valid  = 1'b0;
      chk("dis_accept_rdy", {3'b0, cfg_ready}, 4'b0000);
      tick();
      chk("dis_apply_rdy", {3'b0, cfg_ready}, 4'b0001);
      chk("dis_apply_out", outv(), 4'b0000);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("p5", outv(), p5[i % 5]);
      end

      // Sync at h=30 with P=50
      cfg_disabled(50, 25);
      for (int m = 0; m < 15; m++) begin
         tick();
         chk("pre_sync", outv(), dflt(m));
      end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      chk("sync_h30", outv(), 4'b0000);
      for (int m = 0; m < 25; m++) begin
         tick();
         chk("post_sync", outv(), dflt(m));
      end

      // H=0 constant low
      cfg_disabled(50, 0);
      for (int m = 0; m < 25; m++) begin
         tick();
         chk("h0", outv(), {2'b00, (m == 0), 1'b0});
      end

      // H=60 > P constant high, period_start still marks periods
      cfg_disabled(50, 60);
      for (int m = 0; m < 26; m++) begin
         tick();
         chk("h60", outv(), {2'b11, ((m % 25) == 0), 1'b0});
      end

      // P=1 behaves as P=2
      cfg_disabled(1, 1);
      for (int m = 0; m < 8; m++) begin
         tick();
         chk("p1", outv(), 4'b1010);
      end

      // Asynchronous reset mid-period discards a pending config
      cfg_disabled(50, 25);
      for (int m = 0; m < 10; m++) begin
         tick();
         chk("pre_rst", outv(), dflt(m));
      end
      cfg_valid  = 1'b1;
      cfg_period = 5;
      cfg_high   = 2;
      tick();
      cfg_valid  = 1'b0;
      chk("pre_rst_rdy", {3'b0, cfg_ready}, 4'b0000);
      chk("pre_rst_out", outv(), dflt(10));
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out", outv(), 4'b0000);
      chk("async_rst_rdy", {3'b0, cfg_ready}, 4'b0001);
      tick();
      rst_n = 1'b1;
      for (int m = 0; m < 26; m++) begin
         tick();
         chk("post_rst", outv(), dflt(m % 25));
      end

`ifdef DDR_CLOCK_DIVIDER_PHASE_OFFSET_EN
      // Offset 25 with P=50: sequence 25,27,..,49,1,..
      cfg_offset = 25;
      cfg_disabled(50, 25);
      for (int m = 0; m < 14; m++) begin
         tick();
         chk("offset", outv(), (m < 12) ? 4'b0000 : ((m == 12) ? 4'b0111 : 4'b1100));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
